inference_job_scheduler: RTL and testbench

Sits between the Ethernet/IP receive block and the inference cores. It captures each accepted frame pulse (data frame plus source IP/MAC) into a small circular queue. Queued jobs are dispatched round-robin to NUM_CORES accelerator cores. The block records each job's return address per core and presents core results to the transmit path over a valid/ready handshake.

---
 rtl/inference_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 56 +++++
 rtl/inference_job_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_inference_job_scheduler.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inference_sched_pkg.sv
// Shared types and widths for the inference job scheduler.
package inference_sched_pkg;

    localparam int unsigned IP_ADDR_WIDTH    = 32;
    localparam int unsigned MAC_ADDR_WIDTH   = 48;
    localparam int unsigned DROP_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PENDING = 2'd2
    } core_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the slot after the last
// accepted grant; the pointer moves only when the grant is consumed.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic [PtrW-1:0] grant_idx;
    logic [PtrW-1:0] cand;
    int unsigned     idx;
    int unsigned     nxt;

    always_comb begin
        grant     = '0;
        valid     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PtrW'(idx);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        nxt   = 32'(grant_idx) + 32'd1;
        ptr_d = (nxt >= N) ? '0 : PtrW'(nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && valid) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inference_job_scheduler.sv
// Queues received frames, dispatches them round-robin to inference cores and
// returns each core's result to the frame's source over a valid/ready port.
module inference_job_scheduler
    import inference_sched_pkg::*;
#(
    parameter int unsigned USER_DATA_BYTES = 785,
    parameter int unsigned NUM_CORES       = 2,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter int unsigned RESULT_WIDTH    = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              ENABLE,
    input  logic [USER_DATA_BYTES*8-1:0]      RX_DATA_FRAME,
    input  logic [31:0]                       RX_SRC_IP_ADDRESS,
    input  logic [47:0]                       RX_SRC_MAC_ADDRESS,
    input  logic                              RX_FRAME_READY,
    output logic [USER_DATA_BYTES*8-1:0]      CORE_FRAME,
    output logic [NUM_CORES-1:0]              CORE_START,
    input  logic [NUM_CORES-1:0]              CORE_BUSY,
    input  logic [NUM_CORES-1:0]              CORE_DONE,
    input  logic [NUM_CORES*RESULT_WIDTH-1:0] CORE_RESULT,
    output logic                              RESULT_VALID,
    input  logic                              RESULT_READY,
    output logic [RESULT_WIDTH-1:0]           RESULT_DATA,
    output logic [31:0]                       RESULT_DST_IP,
    output logic [47:0]                       RESULT_DST_MAC,
    output logic                              QUEUE_FULL,
    output logic [15:0]                       DROP_COUNT
);

    localparam int unsigned FrameW   = USER_DATA_BYTES * 8;
    localparam int unsigned QAddrW   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CountW   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned CoreIdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [CountW-1:0] FullCount = CountW'(QUEUE_DEPTH);

    // Job queue storage
    logic [FrameW-1:0]         q_frame [QUEUE_DEPTH];
    logic [IP_ADDR_WIDTH-1:0]  q_ip    [QUEUE_DEPTH];
    logic [MAC_ADDR_WIDTH-1:0] q_mac   [QUEUE_DEPTH];
    logic [QAddrW-1:0]         wr_ptr_q;
    logic [QAddrW-1:0]         rd_ptr_q;
    logic [CountW-1:0]         count_q;
    logic [CountW-1:0]         count_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q;

    // Per-core bookkeeping
    core_state_t               state_q       [NUM_CORES];
    core_state_t               state_d       [NUM_CORES];
    logic [RESULT_WIDTH-1:0]   core_result_q [NUM_CORES];
    logic [IP_ADDR_WIDTH-1:0]  tag_ip_q      [NUM_CORES];
    logic [MAC_ADDR_WIDTH-1:0] tag_mac_q     [NUM_CORES];

    // Registered outputs
    logic [FrameW-1:0]         core_frame_q;
    logic [NUM_CORES-1:0]      core_start_q;
    logic                      result_valid_q;
    logic [RESULT_WIDTH-1:0]   result_data_q;
    logic [IP_ADDR_WIDTH-1:0]  result_ip_q;
    logic [MAC_ADDR_WIDTH-1:0] result_mac_q;
    logic [CoreIdxW-1:0]       res_core_q;

    logic                 queue_empty;
    logic                 queue_full;
    logic                 enq;
    logic                 drop;
    logic                 hs;
    logic                 res_load;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] done_accept;
    logic [NUM_CORES-1:0] disp_req;
    logic [NUM_CORES-1:0] disp_grant;
    logic                 dispatch;
    logic [NUM_CORES-1:0] res_req;
    logic [NUM_CORES-1:0] res_grant;
    logic                 res_sel;
    logic [CoreIdxW-1:0]  disp_idx;
    logic [CoreIdxW-1:0]  res_idx;

    assign queue_empty = (count_q == '0);
    assign queue_full  = (count_q == FullCount);
    // A full queue drops even if a dispatch frees a slot on the same edge.
    assign enq         = RX_FRAME_READY && !queue_full;
    assign drop        = RX_FRAME_READY && queue_full;
    assign hs          = result_valid_q && RESULT_READY;
    assign res_load    = !result_valid_q || hs;
    assign disp_req    = (ENABLE && !queue_empty) ? eligible : '0;
    assign res_req     = res_load ? pending : '0;

    always_comb begin
        eligible    = '0;
        pending     = '0;
        done_accept = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i]    = (state_q[i] == IDLE) && !CORE_BUSY[i];
            pending[i]     = (state_q[i] == PENDING) && !(hs && (res_core_q == CoreIdxW'(i)));
            // A done pulse coinciding with the start pulse belongs to no job.
            done_accept[i] = (state_q[i] == RUNNING) && CORE_DONE[i] && !core_start_q[i];
        end
    end

    always_comb begin
        disp_idx = '0;
        res_idx  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (disp_grant[i]) disp_idx = CoreIdxW'(i);
            if (res_grant[i])  res_idx  = CoreIdxW'(i);
        end
    end

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_disp_arb (
        .clk    (ACLK),
        .rst    (ARESET),
        .req    (disp_req),
        .advance(dispatch),
        .grant  (disp_grant),
        .valid  (dispatch)
    );

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_res_arb (
        .clk    (ACLK),
        .rst    (ARESET),
        .req    (res_req),
        .advance(res_sel),
        .grant  (res_grant),
        .valid  (res_sel)
    );

    always_comb begin
        case ({enq, dispatch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_count_q <= '0;
        end else begin
            if (enq)      wr_ptr_q <= wr_ptr_q + 1'b1;
            if (dispatch) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (drop && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by count and core state.
    always_ff @(posedge ACLK) begin
        if (enq) begin
            q_frame[wr_ptr_q] <= RX_DATA_FRAME;
            q_ip[wr_ptr_q]    <= RX_SRC_IP_ADDRESS;
            q_mac[wr_ptr_q]   <= RX_SRC_MAC_ADDRESS;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (dispatch && disp_grant[i]) begin
                tag_ip_q[i]  <= q_ip[rd_ptr_q];
                tag_mac_q[i] <= q_mac[rd_ptr_q];
            end
            if (done_accept[i]) begin
                core_result_q[i] <= CORE_RESULT[i*RESULT_WIDTH +: RESULT_WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (dispatch && disp_grant[i]) state_d[i] = RUNNING;
                RUNNING: if (done_accept[i]) state_d[i] = PENDING;
                PENDING: if (hs && (res_core_q == CoreIdxW'(i))) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (ARESET) state_q[i] <= IDLE;
            else        state_q[i] <= state_d[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            core_start_q <= '0;
            core_frame_q <= '0;
        end else begin
            core_start_q <= dispatch ? disp_grant : '0;
            if (dispatch) core_frame_q <= q_frame[rd_ptr_q];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_ip_q    <= '0;
            result_mac_q   <= '0;
            res_core_q     <= '0;
        end else if (res_sel) begin
            result_valid_q <= 1'b1;
            result_data_q  <= core_result_q[res_idx];
            result_ip_q    <= tag_ip_q[res_idx];
            result_mac_q   <= tag_mac_q[res_idx];
            res_core_q     <= res_idx;
        end else if (hs) begin
            result_valid_q <= 1'b0;
        end
    end

    assign CORE_FRAME     = core_frame_q;
    assign CORE_START     = core_start_q;
    assign RESULT_VALID   = result_valid_q;
    assign RESULT_DATA    = result_data_q;
    assign RESULT_DST_IP  = result_ip_q;
    assign RESULT_DST_MAC = result_mac_q;
    assign QUEUE_FULL     = queue_full;
    assign DROP_COUNT     = drop_count_q;

endmodule

// File: tb/tb_inference_job_scheduler.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_inference_job_scheduler;

    localparam int UDB = 785;
    localparam int NC  = 2;
    localparam int QD  = 2;
    localparam int RW  = 8;
    localparam int FW  = UDB * 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PEND = 2;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic            ENABLE;
    logic [FW-1:0]   RX_DATA_FRAME;
    logic [31:0]     RX_SRC_IP_ADDRESS;
    logic [47:0]     RX_SRC_MAC_ADDRESS;
    logic            RX_FRAME_READY;
    logic [FW-1:0]   CORE_FRAME;
    logic [NC-1:0]   CORE_START;
    logic [NC-1:0]   CORE_BUSY;
    logic [NC-1:0]   CORE_DONE;
    logic [NC*RW-1:0] CORE_RESULT;
    logic            RESULT_VALID;
    logic            RESULT_READY;
    logic [RW-1:0]   RESULT_DATA;
    logic [31:0]     RESULT_DST_IP;
    logic [47:0]     RESULT_DST_MAC;
    logic            QUEUE_FULL;
    logic [15:0]     DROP_COUNT;

    int n_cmp  = 0;
    int n_fail = 0;

    inference_job_scheduler #(
        .USER_DATA_BYTES(UDB),
        .NUM_CORES      (NC),
        .QUEUE_DEPTH    (QD),
        .RESULT_WIDTH   (RW)
    ) dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .ENABLE            (ENABLE),
        .RX_DATA_FRAME     (RX_DATA_FRAME),
        .RX_SRC_IP_ADDRESS (RX_SRC_IP_ADDRESS),
        .RX_SRC_MAC_ADDRESS(RX_SRC_MAC_ADDRESS),
        .RX_FRAME_READY    (RX_FRAME_READY),
        .CORE_FRAME        (CORE_FRAME),
        .CORE_START        (CORE_START),
        .CORE_BUSY         (CORE_BUSY),
        .CORE_DONE         (CORE_DONE),
        .CORE_RESULT       (CORE_RESULT),
        .RESULT_VALID      (RESULT_VALID),
        .RESULT_READY      (RESULT_READY),
        .RESULT_DATA       (RESULT_DATA),
        .RESULT_DST_IP     (RESULT_DST_IP),
        .RESULT_DST_MAC    (RESULT_DST_MAC),
        .QUEUE_FULL        (QUEUE_FULL),
        .DROP_COUNT        (DROP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    // Reference model state
    int            m_st   [NC];
    logic [RW-1:0] m_res  [NC];
    logic [31:0]   m_tip  [NC];
    logic [47:0]   m_tmac [NC];
    int            m_dptr, m_rptr;
    logic [FW-1:0] mq_f   [$];
    logic [31:0]   mq_ip  [$];
    logic [47:0]   mq_mac [$];
    logic [NC-1:0] e_start;
    logic [FW-1:0] e_frame;
    logic          e_valid;
    logic [RW-1:0] e_data;
    logic [31:0]   e_ip;
    logic [47:0]   e_mac;
    int            e_core;
    logic [15:0]   e_drop;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic make_frame(input logic [7:0] b0, output logic [FW-1:0] f);
        for (int b = 0; b < UDB; b++) f[b*8 +: 8] = 8'($urandom);
        f[7:0] = b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input logic [31:0] ip,
                              input logic [47:0] mac);
        RX_DATA_FRAME      = f;
        RX_SRC_IP_ADDRESS  = ip;
        RX_SRC_MAC_ADDRESS = mac;
        RX_FRAME_READY     = 1'b1;
        tick();
        RX_FRAME_READY     = 1'b0;
    endtask

    task automatic do_reset();
        ARESET         = 1'b1;
        ENABLE         = 1'b1;
        RX_FRAME_READY = 1'b0;
        CORE_BUSY      = '0;
        CORE_DONE      = '0;
        CORE_RESULT    = '0;
        RESULT_READY   = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_st[c] = M_IDLE; m_res[c] = '0; m_tip[c] = '0; m_tmac[c] = '0;
        end
        m_dptr = 0; m_rptr = 0;
        mq_f.delete(); mq_ip.delete(); mq_mac.delete();
        e_start = '0; e_frame = '0; e_valid = 1'b0; e_data = '0;
        e_ip = '0; e_mac = '0; e_core = 0; e_drop = '0;
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        int  g, r, hs_core, pre_size, c;
        bit  hs;
        int  nst [NC];
        pre_size = mq_f.size();
        hs       = e_valid && RESULT_READY;
        hs_core  = hs ? e_core : -1;
        g = -1;
        if (ENABLE && pre_size > 0) begin
            for (int k = 0; k < NC; k++) begin
                c = (m_dptr + k) % NC;
                if (g < 0 && m_st[c] == M_IDLE && !CORE_BUSY[c]) g = c;
            end
        end
        r = -1;
        if (!e_valid || hs) begin
            for (int k = 0; k < NC; k++) begin
                c = (m_rptr + k) % NC;
                if (r < 0 && m_st[c] == M_PEND && c != hs_core) r = c;
            end
        end
        for (int k = 0; k < NC; k++) nst[k] = m_st[k];
        if (r >= 0) begin
            e_valid = 1'b1; e_data = m_res[r]; e_ip = m_tip[r]; e_mac = m_tmac[r];
            e_core = r; m_rptr = (r + 1) % NC;
        end else if (hs) begin
            e_valid = 1'b0;
        end
        if (hs) nst[hs_core] = M_IDLE;
        for (int k = 0; k < NC; k++) begin
            if (m_st[k] == M_RUN && CORE_DONE[k] && !e_start[k]) begin
                nst[k]   = M_PEND;
                m_res[k] = CORE_RESULT[k*RW +: RW];
            end
        end
        e_start = '0;
        if (g >= 0) begin
            nst[g]     = M_RUN;
            m_tip[g]   = mq_ip[0];
            m_tmac[g]  = mq_mac[0];
            e_frame    = mq_f[0];
            e_start[g] = 1'b1;
            m_dptr     = (g + 1) % NC;
            void'(mq_f.pop_front()); void'(mq_ip.pop_front()); void'(mq_mac.pop_front());
        end
        if (RX_FRAME_READY) begin
            if (pre_size == QD) begin
                if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
            end else begin
                mq_f.push_back(RX_DATA_FRAME);
                mq_ip.push_back(RX_SRC_IP_ADDRESS);
                mq_mac.push_back(RX_SRC_MAC_ADDRESS);
            end
        end
        for (int k = 0; k < NC; k++) m_st[k] = nst[k];
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (CORE_START !== 2'b00) begin n_fail++;
            $display("FAIL reset_start: got %b want 00", CORE_START); end
        n_cmp++; if (RESULT_VALID !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", RESULT_VALID); end
        n_cmp++; if (QUEUE_FULL !== 1'b0 || DROP_COUNT !== 16'd0) begin n_fail++;
            $display("FAIL reset_queue: got full=%b drop=%0d want 0/0", QUEUE_FULL, DROP_COUNT); end
        n_cmp++; if (CORE_FRAME !== '0 || RESULT_DATA !== '0 || RESULT_DST_IP !== '0) begin n_fail++;
            $display("FAIL reset_data: got frame=%h data=%h ip=%h want 0",
                     CORE_FRAME[63:0], RESULT_DATA, RESULT_DST_IP); end
    endtask

    task automatic test_single_job();
        logic [FW-1:0] f;
        do_reset();
        make_frame(8'h5A, f);
        send_frame(f, 32'hC0A80002, 48'h0200_0000_0001);
        tick();
        n_cmp++; if (CORE_START !== 2'b01) begin n_fail++;
            $display("FAIL single_start: got %b want 01", CORE_START); end
        n_cmp++; if (CORE_FRAME !== f) begin n_fail++;
            $display("FAIL single_frame: got %h want %h", CORE_FRAME[63:0], f[63:0]); end
        tick();
        n_cmp++; if (CORE_START !== 2'b00) begin n_fail++;
            $display("FAIL single_start_pulse: got %b want 00", CORE_START); end
        CORE_RESULT = {8'h00, 8'h07};
        CORE_DONE   = 2'b01;
        tick();
        CORE_DONE = 2'b00;
        tick();
        n_cmp++; if (RESULT_VALID !== 1'b1 || RESULT_DATA !== 8'h07) begin n_fail++;
            $display("FAIL single_result: got v=%b d=%h want 1/07", RESULT_VALID, RESULT_DATA); end
        n_cmp++; if (RESULT_DST_IP !== 32'hC0A80002 || RESULT_DST_MAC !== 48'h0200_0000_0001) begin
            n_fail++;
            $display("FAIL single_addr: got %h/%h want c0a80002/020000000001",
                     RESULT_DST_IP, RESULT_DST_MAC); end
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;
        n_cmp++; if (RESULT_VALID !== 1'b0) begin n_fail++;
            $display("FAIL single_drain: got v=%b want 0", RESULT_VALID); end
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] f1, f2, f3;
        do_reset();
        make_frame(8'h11, f1); make_frame(8'h22, f2); make_frame(8'h33, f3);
        send_frame(f1, 32'h0A000001, 48'h1);
        send_frame(f2, 32'h0A000002, 48'h2);
        n_cmp++; if (CORE_START !== 2'b01 || CORE_FRAME !== f1) begin n_fail++;
            $display("FAIL rr_first: got %b/%h want 01/%h", CORE_START, CORE_FRAME[63:0], f1[63:0]); end
        send_frame(f3, 32'h0A000003, 48'h3);
        n_cmp++; if (CORE_START !== 2'b10 || CORE_FRAME !== f2) begin n_fail++;
            $display("FAIL rr_second: got %b/%h want 10/%h", CORE_START, CORE_FRAME[63:0], f2[63:0]); end
        tick();
        n_cmp++; if (CORE_START !== 2'b00) begin n_fail++;
            $display("FAIL rr_third_waits: got %b want 00", CORE_START); end
        CORE_RESULT = {8'h00, 8'h44};
        CORE_DONE   = 2'b01;
        tick();
        CORE_DONE = 2'b00;
        tick();
        n_cmp++; if (RESULT_VALID !== 1'b1 || RESULT_DATA !== 8'h44 || RESULT_DST_IP !== 32'h0A000001) begin
            n_fail++;
            $display("FAIL rr_result: got v=%b d=%h ip=%h want 1/44/0a000001",
                     RESULT_VALID, RESULT_DATA, RESULT_DST_IP); end
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;
        tick();
        n_cmp++; if (CORE_START !== 2'b01 || CORE_FRAME !== f3) begin n_fail++;
            $display("FAIL rr_third: got %b/%h want 01/%h", CORE_START, CORE_FRAME[63:0], f3[63:0]); end
        n_cmp++; if (DROP_COUNT !== 16'd0) begin n_fail++;
            $display("FAIL rr_drops: got %0d want 0", DROP_COUNT); end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] f [4];
        do_reset();
        CORE_BUSY = 2'b11;
        for (int i = 0; i < 4; i++) make_frame(8'(i + 1), f[i]);
        send_frame(f[0], 32'h1, 48'h1);
        n_cmp++; if (QUEUE_FULL !== 1'b0) begin n_fail++;
            $display("FAIL ovf_not_full: got %b want 0", QUEUE_FULL); end
        send_frame(f[1], 32'h2, 48'h2);
        n_cmp++; if (QUEUE_FULL !== 1'b1) begin n_fail++;
            $display("FAIL ovf_full: got %b want 1", QUEUE_FULL); end
        send_frame(f[2], 32'h3, 48'h3);
        send_frame(f[3], 32'h4, 48'h4);
        n_cmp++; if (DROP_COUNT !== 16'd2 || CORE_START !== 2'b00) begin n_fail++;
            $display("FAIL ovf_drops: got %0d/%b want 2/00", DROP_COUNT, CORE_START); end
        CORE_BUSY = 2'b00;
        tick();
        n_cmp++; if (CORE_START !== 2'b01 || CORE_FRAME !== f[0]) begin n_fail++;
            $display("FAIL ovf_first: got %b/%h want 01/%h", CORE_START, CORE_FRAME[63:0], f[0][63:0]); end
        tick();
        n_cmp++; if (CORE_START !== 2'b10 || CORE_FRAME !== f[1]) begin n_fail++;
            $display("FAIL ovf_second: got %b/%h want 10/%h", CORE_START, CORE_FRAME[63:0], f[1][63:0]); end
        n_cmp++; if (QUEUE_FULL !== 1'b0) begin n_fail++;
            $display("FAIL ovf_drained: got %b want 0", QUEUE_FULL); end
    endtask

    task automatic test_simultaneous_done();
        logic [FW-1:0] f1, f2;
        do_reset();
        make_frame(8'hA1, f1); make_frame(8'hA2, f2);
        send_frame(f1, 32'hC0A80101, 48'hAA);
        send_frame(f2, 32'hC0A80102, 48'hBB);
        tick();
        tick();
        CORE_RESULT = {8'h09, 8'h03};
        CORE_DONE   = 2'b11;
        tick();
        CORE_DONE = 2'b00;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (RESULT_VALID !== 1'b1 || RESULT_DATA !== 8'h03 || RESULT_DST_IP !== 32'hC0A80101) begin
                n_fail++;
                $display("FAIL simul_hold%0d: got v=%b d=%h ip=%h want 1/03/c0a80101",
                         i, RESULT_VALID, RESULT_DATA, RESULT_DST_IP);
            end
            tick();
        end
        RESULT_READY = 1'b1;
        tick();
        n_cmp++; if (RESULT_VALID !== 1'b1 || RESULT_DATA !== 8'h09 || RESULT_DST_MAC !== 48'hBB) begin
            n_fail++;
            $display("FAIL simul_second: got v=%b d=%h mac=%h want 1/09/bb",
                     RESULT_VALID, RESULT_DATA, RESULT_DST_MAC); end
        tick();
        RESULT_READY = 1'b0;
        n_cmp++; if (RESULT_VALID !== 1'b0) begin n_fail++;
            $display("FAIL simul_empty: got v=%b want 0", RESULT_VALID); end
    endtask

    task automatic test_enable_gating();
        logic [FW-1:0] f1, f2;
        do_reset();
        ENABLE = 1'b0;
        make_frame(8'hE1, f1); make_frame(8'hE2, f2);
        send_frame(f1, 32'h5, 48'h5);
        send_frame(f2, 32'h6, 48'h6);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (CORE_START !== 2'b00 || QUEUE_FULL !== 1'b1) begin n_fail++;
                $display("FAIL gate_hold%0d: got start=%b full=%b want 00/1", i, CORE_START, QUEUE_FULL); end
            tick();
        end
        ENABLE = 1'b1;
        tick();
        n_cmp++; if (CORE_START !== 2'b01 || CORE_FRAME !== f1) begin n_fail++;
            $display("FAIL gate_release: got %b/%h want 01/%h", CORE_START, CORE_FRAME[63:0], f1[63:0]); end
        tick();
        n_cmp++; if (CORE_START !== 2'b10 || CORE_FRAME !== f2) begin n_fail++;
            $display("FAIL gate_second: got %b/%h want 10/%h", CORE_START, CORE_FRAME[63:0], f2[63:0]); end
    endtask

    task automatic test_reset_mid_run();
        logic [FW-1:0] f1, f2;
        do_reset();
        make_frame(8'hC1, f1); make_frame(8'hC2, f2);
        send_frame(f1, 32'h7, 48'h7);
        CORE_BUSY = 2'b10;
        send_frame(f2, 32'h8, 48'h8);
        tick();
        n_cmp++; if (CORE_START !== 2'b00 || CORE_FRAME !== f1) begin n_fail++;
            $display("FAIL midrst_pre: got %b/%h want 00/%h", CORE_START, CORE_FRAME[63:0], f1[63:0]); end
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        CORE_BUSY = 2'b00;
        n_cmp++;
        if (CORE_START !== '0 || CORE_FRAME !== '0 || RESULT_VALID !== 1'b0 || RESULT_DATA !== '0 ||
            RESULT_DST_IP !== '0 || RESULT_DST_MAC !== '0 || QUEUE_FULL !== 1'b0 ||
            DROP_COUNT !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got start=%b frame=%h v=%b full=%b drop=%0d want all 0",
                     CORE_START, CORE_FRAME[63:0], RESULT_VALID, QUEUE_FULL, DROP_COUNT);
        end
        CORE_RESULT = {8'h00, 8'h55};
        CORE_DONE   = 2'b01;
        tick();
        CORE_DONE = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (RESULT_VALID !== 1'b0 || CORE_START !== 2'b00) begin n_fail++;
                $display("FAIL midrst_stale%0d: got v=%b start=%b want 0/00", i, RESULT_VALID, CORE_START); end
        end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            ENABLE = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < NC; c++) begin
                CORE_BUSY[c] = ($urandom_range(0, 3) == 0);
                if (m_st[c] == M_RUN) CORE_DONE[c] = ($urandom_range(0, 2) == 0);
                else                  CORE_DONE[c] = ($urandom_range(0, 15) == 0);
            end
            CORE_RESULT  = NC*RW'($urandom);
            RESULT_READY = $urandom_range(0, 1) == 1;
            RX_FRAME_READY = $urandom_range(0, 1) == 1;
            if (RX_FRAME_READY) begin
                for (int b = 0; b < UDB; b += 97) RX_DATA_FRAME[b*8 +: 8] = 8'($urandom);
                RX_SRC_IP_ADDRESS  = $urandom;
                RX_SRC_MAC_ADDRESS = {16'($urandom), 32'($urandom)};
            end
            model_step();
            tick();
            n_cmp++; if (CORE_START !== e_start) begin n_fail++;
                $display("FAIL rand_start@%0d: got %b want %b", cyc, CORE_START, e_start); end
            n_cmp++; if (CORE_FRAME !== e_frame) begin n_fail++;
                $display("FAIL rand_frame@%0d: got %h want %h", cyc, CORE_FRAME[63:0], e_frame[63:0]); end
            n_cmp++; if (RESULT_VALID !== e_valid) begin n_fail++;
                $display("FAIL rand_valid@%0d: got %b want %b", cyc, RESULT_VALID, e_valid); end
            n_cmp++;
            if (RESULT_DATA !== e_data || RESULT_DST_IP !== e_ip || RESULT_DST_MAC !== e_mac) begin
                n_fail++;
                $display("FAIL rand_result@%0d: got %h/%h/%h want %h/%h/%h", cyc, RESULT_DATA,
                         RESULT_DST_IP, RESULT_DST_MAC, e_data, e_ip, e_mac);
            end
            n_cmp++; if (QUEUE_FULL !== (mq_f.size() == QD)) begin n_fail++;
                $display("FAIL rand_full@%0d: got %b want %b", cyc, QUEUE_FULL, mq_f.size() == QD); end
            n_cmp++; if (DROP_COUNT !== e_drop) begin n_fail++;
                $display("FAIL rand_drop@%0d: got %0d want %0d", cyc, DROP_COUNT, e_drop); end
        end
        RX_FRAME_READY = 1'b0;
        CORE_DONE      = '0;
    endtask

    initial begin
        ARESET             = 1'b1;
        ENABLE             = 1'b1;
        RX_DATA_FRAME      = '0;
        RX_SRC_IP_ADDRESS  = '0;
        RX_SRC_MAC_ADDRESS = '0;
        RX_FRAME_READY     = 1'b0;
        CORE_BUSY          = '0;
        CORE_DONE          = '0;
        CORE_RESULT        = '0;
        RESULT_READY       = 1'b0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_overflow();
        test_simultaneous_done();
        test_enable_gating();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
